// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and frame timing helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLK_DIV = 434;

    function automatic int frame_len(input int data_w, input int parity_en,
                                     input int stop_bits, input int clk_div);
        return (1 + data_w + parity_en + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle of the FIFO read-side pins and the serial-side status pins of the UART transmitter.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              tx_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              tx;
    logic              busy;
    logic              frame_done;

    modport master (
        output tx_en, fifo_dout, fifo_empty,
        input  fifo_rd, tx, busy, frame_done
    );

    modport slave (
        input  tx_en, fifo_dout, fifo_empty,
        output fifo_rd, tx, busy, frame_done
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: bit_tick marks the last cycle of every CLK_DIV-cycle bit period.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    // Wraps on its own so multi-bit states (DATA, two STOP bits) need no explicit restart
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each byte as a UART frame, chaining frames with no idle gap.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.slave  bus
);
    localparam int IDX_W = $clog2(DATA_W + 1);

    state_t            state, state_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic [IDX_W-1:0]  bit_idx, bit_idx_next;
    logic              stop_idx, stop_idx_next;
    logic              parity, parity_next;
    logic              tx_q, tx_next;
    logic              rd_q;
    logic              bit_tick;
    logic              restart;
    logic              last_stop;
    logic              frame_end;
    logic              load;

    assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;
    assign frame_end = (state == ST_STOP) && bit_tick && last_stop;
    assign load      = bus.tx_en && !bus.fifo_empty && ((state == ST_IDLE) || frame_end);
    assign restart   = (state_next != state);

    uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            parity   <= 1'b0;
            tx_q     <= 1'b1;
            rd_q     <= 1'b0;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            parity   <= parity_next;
            tx_q     <= tx_next;
            rd_q     <= load;
        end
    end

    // tx_next is the line level for the state being entered, so tx stays a pure flop output
    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        parity_next   = parity;
        tx_next       = tx_q;

        case (state)
            ST_IDLE: begin
                tx_next = 1'b1;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_next   = ST_DATA;
                    tx_next      = shift[0];
                    shift_next   = shift >> 1;
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx == IDX_W'(DATA_W - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_next = ST_PARITY;
                            tx_next    = parity;
                        end else begin
                            state_next    = ST_STOP;
                            tx_next       = 1'b1;
                            stop_idx_next = 1'b0;
                        end
                    end else begin
                        tx_next      = shift[0];
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_next    = ST_STOP;
                    tx_next       = 1'b1;
                    stop_idx_next = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Parity is taken from the byte as loaded because the shift register is consumed in DATA
        if (load) begin
            state_next  = ST_START;
            tx_next     = 1'b0;
            shift_next  = bus.fifo_dout;
            parity_next = (^bus.fifo_dout) ^ (PARITY_ODD != 0);
        end
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd    = rd_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four parameter variants fed by a FIFO model, checked against a frame-level model and a UART receiver.
module tb_fifo_uart_tx;

    localparam int D = 4;
    localparam logic [3:0] PEN_MASK   = 4'b0110;
    localparam logic [3:0] ODD_MASK   = 4'b0100;
    localparam logic [3:0] STOP2_MASK = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tx_en_a;
    logic [3:0] tx_a, rd_a, busy_a, done_a;

    logic [7:0] fifo_mem [4][64];
    logic [5:0] wp [4] = '{default: 6'd0};
    logic [5:0] rp [4] = '{default: 6'd0};
    int         under_cnt = 0;

    int tests = 0;
    int fails = 0;

    logic       exp_tx[$], exp_rd[$], exp_done[$], exp_busy[$];
    logic       cap_tx[$], cap_rd[$], cap_done[$], cap_busy[$];
    logic [7:0] exp_bytes[$], rx_bytes[$];
    int         rx_err;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : ch
        fifo_uart_tx_if #(.DATA_W(8)) bus ();

        assign bus.tx_en      = tx_en_a[g];
        assign bus.fifo_dout  = fifo_mem[g][rp[g]];
        assign bus.fifo_empty = (rp[g] == wp[g]);
        assign tx_a[g]        = bus.tx;
        assign rd_a[g]        = bus.fifo_rd;
        assign busy_a[g]      = bus.busy;
        assign done_a[g]      = bus.frame_done;

        fifo_uart_tx #(
            .DATA_W     (8),
            .CLK_DIV    (D),
            .PARITY_EN  (PEN_MASK[g] ? 1 : 0),
            .PARITY_ODD (ODD_MASK[g] ? 1 : 0),
            .STOP_BITS  (STOP2_MASK[g] ? 2 : 1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Show-ahead FIFO model: pops at the edge where fifo_rd is high
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_a[i] === 1'b1) begin
                if (rp[i] == wp[i]) under_cnt <= under_cnt + 1;
                else                rp[i] <= rp[i] + 6'd1;
            end
        end
    end

    task automatic push(input int c, input logic [7:0] b);
        fifo_mem[c][wp[c]] = b;
        wp[c] = wp[c] + 6'd1;
    endtask

    task automatic clear_all();
        exp_tx.delete(); exp_rd.delete(); exp_done.delete(); exp_busy.delete();
        exp_bytes.delete(); rx_bytes.delete();
    endtask

    function automatic void add_frame(input logic [7:0] b, input int c);
        int   pen, stops, nb;
        logic v;
        pen   = PEN_MASK[c] ? 1 : 0;
        stops = STOP2_MASK[c] ? 2 : 1;
        nb    = 1 + 8 + pen + stops;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)                  v = 1'b0;
            else if (i <= 8)             v = b[i-1];
            else if (pen == 1 && i == 9) v = (^b) ^ ODD_MASK[c];
            else                         v = 1'b1;
            for (int k = 0; k < D; k++) begin
                exp_tx.push_back(v);
                exp_rd.push_back(i == 0 && k == 0);
                exp_done.push_back(i == nb - 1 && k == D - 1);
                exp_busy.push_back(1'b1);
            end
        end
        exp_bytes.push_back(b);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1);
            exp_rd.push_back(1'b0);
            exp_done.push_back(1'b0);
            exp_busy.push_back(1'b0);
        end
    endfunction

    task automatic capture(input int c);
        int n;
        n = exp_tx.size();
        cap_tx.delete(); cap_rd.delete(); cap_done.delete(); cap_busy.delete();
        repeat (n) begin
            @(negedge clk);
            cap_tx.push_back(tx_a[c]);
            cap_rd.push_back(rd_a[c]);
            cap_done.push_back(done_a[c]);
            cap_busy.push_back(busy_a[c]);
        end
    endtask

    function automatic int trace_diff();
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (cap_tx[i] !== exp_tx[i] || cap_rd[i] !== exp_rd[i] ||
                cap_done[i] !== exp_done[i] || cap_busy[i] !== exp_busy[i])
                return i;
        end
        return -1;
    endfunction

    // Reference receiver: finds each falling edge and samples every bit at its centre
    task automatic rx_decode(input int c);
        int         i, nb, pen, stops;
        logic [7:0] b;
        pen   = PEN_MASK[c] ? 1 : 0;
        stops = STOP2_MASK[c] ? 2 : 1;
        nb    = 1 + 8 + pen + stops;
        rx_bytes.delete();
        rx_err = 0;
        i = 0;
        while (i < cap_tx.size()) begin
            if (cap_tx[i] !== 1'b0) begin
                i++;
            end else if (i + nb * D > cap_tx.size()) begin
                rx_err++;
                break;
            end else begin
                if (cap_tx[i + D/2] !== 1'b0) rx_err++;
                for (int k = 0; k < 8; k++) b[k] = cap_tx[i + (1 + k) * D + D/2];
                if (pen == 1 && cap_tx[i + 9 * D + D/2] !== ((^b) ^ ODD_MASK[c])) rx_err++;
                for (int s = 0; s < stops; s++)
                    if (cap_tx[i + (9 + pen + s) * D + D/2] !== 1'b1) rx_err++;
                rx_bytes.push_back(b);
                i = i + (nb - 1) * D + D/2 + 1;
            end
        end
    endtask

    function automatic bit rx_mismatch();
        if (rx_err != 0 || rx_bytes.size() != exp_bytes.size()) return 1'b1;
        for (int i = 0; i < rx_bytes.size(); i++)
            if (rx_bytes[i] !== exp_bytes[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        tx_en_a = 4'h0;
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_a, busy_a, rd_a, done_a} !== 16'hF000) begin
            fails++;
            $display("[TB] FAIL reset_values got tx=%b busy=%b rd=%b done=%b want tx=1111 others 0000",
                     tx_a, busy_a, rd_a, done_a);
        end
        rst = 1'b1;
        @(negedge clk);
        tx_en_a[0] = 1'b1;
        push(0, 8'h00);
        repeat (10) @(negedge clk);
        tests++;
        if (tx_a[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midframe_tx_low got %b want 0", tx_a[0]);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_midframe got tx=%b busy=%b want tx=1 busy=0", tx_a[0], busy_a[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (busy_a[0] !== 1'b0 || rp[0] !== wp[0] || rd_a[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_discard got busy=%b rd=%b rp=%0d wp=%0d want idle with byte consumed",
                     busy_a[0], rd_a[0], rp[0], wp[0]);
        end
    endtask

    task automatic test_single_byte();
        int         d;
        logic [9:0] spec_bits, got_bits;
        spec_bits = 10'b0101001011;
        clear_all();
        add_frame(8'hA5, 0);
        add_idle(8);
        @(negedge clk);
        push(0, 8'hA5);
        capture(0);
        d = trace_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("[TB] FAIL a5_trace idx=%0d got tx/rd/done/busy=%b%b%b%b want %b%b%b%b", d,
                     cap_tx[d], cap_rd[d], cap_done[d], cap_busy[d], exp_tx[d], exp_rd[d], exp_done[d], exp_busy[d]);
        end
        for (int k = 0; k < 10; k++) got_bits[9-k] = cap_tx[k * D + D/2];
        tests++;
        if (got_bits !== spec_bits) begin
            fails++;
            $display("[TB] FAIL a5_bits got %b want %b", got_bits, spec_bits);
        end
        rx_decode(0);
        tests++;
        if (rx_mismatch()) begin
            fails++;
            $display("[TB] FAIL a5_rx got %0d bytes (%0d errors) want %0d bytes", rx_bytes.size(), rx_err, exp_bytes.size());
        end
    endtask

    task automatic test_back_to_back();
        int d;
        clear_all();
        add_frame(8'h00, 0); add_frame(8'hFF, 0); add_frame(8'h55, 0);
        add_idle(4);
        @(negedge clk);
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
        capture(0);
        d = trace_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("[TB] FAIL b2b_trace idx=%0d got tx/rd/done/busy=%b%b%b%b want %b%b%b%b", d,
                     cap_tx[d], cap_rd[d], cap_done[d], cap_busy[d], exp_tx[d], exp_rd[d], exp_done[d], exp_busy[d]);
        end
        rx_decode(0);
        tests++;
        if (rx_mismatch()) begin
            fails++;
            $display("[TB] FAIL b2b_rx got %0d bytes (%0d errors) want %0d bytes", rx_bytes.size(), rx_err, exp_bytes.size());
        end
    endtask

    task automatic test_parity();
        int         d;
        logic [7:0] r;
        for (int c = 1; c <= 2; c++) begin
            r = 8'($urandom);
            clear_all();
            add_frame(8'h07, c); add_frame(r, c);
            add_idle(4);
            tx_en_a[c] = 1'b1;
            @(negedge clk);
            push(c, 8'h07); push(c, r);
            capture(c);
            d = trace_diff();
            tests++;
            if (d != -1) begin
                fails++;
                $display("[TB] FAIL parity_trace ch=%0d idx=%0d got tx/rd/done/busy=%b%b%b%b want %b%b%b%b", c, d,
                         cap_tx[d], cap_rd[d], cap_done[d], cap_busy[d], exp_tx[d], exp_rd[d], exp_done[d], exp_busy[d]);
            end
            tests++;
            if (cap_tx[9 * D + D/2] !== (c == 1)) begin
                fails++;
                $display("[TB] FAIL parity_bit ch=%0d got %b want %b", c, cap_tx[9 * D + D/2], (c == 1));
            end
            rx_decode(c);
            tests++;
            if (rx_mismatch()) begin
                fails++;
                $display("[TB] FAIL parity_rx ch=%0d got %0d bytes (%0d errors) want %0d bytes",
                         c, rx_bytes.size(), rx_err, exp_bytes.size());
            end
        end
    endtask

    task automatic test_stop_bits();
        int         d;
        logic [7:0] sw;
        clear_all();
        add_frame(8'h3C, 3);
        add_idle(6);
        tx_en_a[3] = 1'b1;
        @(negedge clk);
        push(3, 8'h3C);
        capture(3);
        d = trace_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("[TB] FAIL stop2_trace idx=%0d got tx/rd/done/busy=%b%b%b%b want %b%b%b%b", d,
                     cap_tx[d], cap_rd[d], cap_done[d], cap_busy[d], exp_tx[d], exp_rd[d], exp_done[d], exp_busy[d]);
        end
        for (int k = 0; k < 8; k++) sw[k] = cap_tx[36 + k];
        tests++;
        if (sw !== 8'hFF || cap_done[43] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stop2_window got stop=%b done43=%b want 11111111 and 1", sw, cap_done[43]);
        end
    endtask

    task automatic test_tx_en_drop();
        int d;
        clear_all();
        add_frame(8'h3C, 3);
        add_idle(16);
        tx_en_a[3] = 1'b1;
        @(negedge clk);
        push(3, 8'h3C); push(3, 8'($urandom));
        fork
            capture(3);
            begin
                repeat (10) @(negedge clk);
                tx_en_a[3] = 1'b0;
            end
        join
        d = trace_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("[TB] FAIL txen_drop_trace idx=%0d got tx/rd/done/busy=%b%b%b%b want %b%b%b%b", d,
                     cap_tx[d], cap_rd[d], cap_done[d], cap_busy[d], exp_tx[d], exp_rd[d], exp_done[d], exp_busy[d]);
        end
        tests++;
        if (wp[3] - rp[3] !== 6'd1) begin
            fails++;
            $display("[TB] FAIL txen_drop_fifo got %0d bytes left want 1", wp[3] - rp[3]);
        end
        wp[3] = rp[3];
    endtask

    task automatic test_idle_restart();
        int         d;
        logic [7:0] r;
        r = 8'($urandom);
        clear_all();
        add_frame(r, 0);
        add_idle(10);
        add_frame(8'h5A, 0);
        add_idle(4);
        @(negedge clk);
        push(0, r);
        fork
            capture(0);
            begin
                repeat (50) @(negedge clk);
                push(0, 8'h5A);
            end
        join
        d = trace_diff();
        tests++;
        if (d != -1) begin
            fails++;
            $display("[TB] FAIL restart_trace idx=%0d got tx/rd/done/busy=%b%b%b%b want %b%b%b%b", d,
                     cap_tx[d], cap_rd[d], cap_done[d], cap_busy[d], exp_tx[d], exp_rd[d], exp_done[d], exp_busy[d]);
        end
        tests++;
        if ({cap_busy[49], cap_tx[49], cap_tx[50]} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL restart_edge got busy49/tx49/tx50=%b%b%b want 010", cap_busy[49], cap_tx[49], cap_tx[50]);
        end
        rx_decode(0);
        tests++;
        if (rx_mismatch()) begin
            fails++;
            $display("[TB] FAIL restart_rx got %0d bytes (%0d errors) want %0d bytes", rx_bytes.size(), rx_err, exp_bytes.size());
        end
    endtask

    task automatic test_random();
        int         d, n;
        logic [7:0] b;
        for (int c = 0; c < 4; c++) begin
            clear_all();
            n = $urandom_range(2, 4);
            tx_en_a[c] = 1'b1;
            @(negedge clk);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                add_frame(b, c);
                push(c, b);
            end
            add_idle(4);
            capture(c);
            d = trace_diff();
            tests++;
            if (d != -1) begin
                fails++;
                $display("[TB] FAIL random_trace ch=%0d idx=%0d got tx/rd/done/busy=%b%b%b%b want %b%b%b%b", c, d,
                         cap_tx[d], cap_rd[d], cap_done[d], cap_busy[d], exp_tx[d], exp_rd[d], exp_done[d], exp_busy[d]);
            end
            rx_decode(c);
            tests++;
            if (rx_mismatch()) begin
                fails++;
                $display("[TB] FAIL random_rx ch=%0d got %0d bytes (%0d errors) want %0d bytes",
                         c, rx_bytes.size(), rx_err, exp_bytes.size());
            end
        end
        tests++;
        if (under_cnt !== 0) begin
            fails++;
            $display("[TB] FAIL fifo_underflow got %0d pops from empty FIFO want 0", under_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity();
        test_stop_bits();
        test_tx_en_drop();
        test_idle_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
